// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Function : Byte/half/word load-store front end for a word-only data memory.
//            Sub-word stores use read-modify-write. Optional MISALIGN_TRAP_EN
//            turns misaligned half/word requests into error responses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int MEM_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LD     = 3'd1;
    localparam logic [2:0] c_RMW_RD = 3'd2;
    localparam logic [2:0] c_RMW_WR = 3'd3;
    localparam logic [2:0] c_WR     = 3'd4;
    localparam logic [2:0] c_RESP   = 3'd5;
    localparam logic [2:0] c_ERR    = 3'd6;

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;
    localparam logic [1:0] c_SZ_RSVD = 2'b11;

    localparam logic [32:0] c_ADDR_LIMIT = 33'(MEM_WORDS) << 2;

    logic [2:0]  r_state;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic [31:0] r_rdata;

    logic        w_misaligned;
    logic        w_bad;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;
    logic [31:0] w_merged;

`ifdef MISALIGN_TRAP_EN
    assign w_misaligned = ((req_size == c_SZ_HALF) && req_addr[0]) ||
                          ((req_size == c_SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_bad = (req_size == c_SZ_RSVD) || w_misaligned ||
                   ({1'b0, req_addr} >= c_ADDR_LIMIT);

    // Lane selection ignores the low address bits below the access size,
    // which is what lets misaligned requests proceed when trapping is off.
    assign w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        w_ld_data = mem_rdata;
        case (r_size)
            c_SZ_BYTE: w_ld_data = {{24{r_signed & w_byte[7]}}, w_byte};
            c_SZ_HALF: w_ld_data = {{16{r_signed & w_half[15]}}, w_half};
            default:   w_ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        w_merged = r_merge;
        case (r_size)
            c_SZ_BYTE: w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            c_SZ_HALF: begin
                if (r_addr[1]) w_merged[31:16] = r_wdata[15:0];
                else           w_merged[15:0]  = r_wdata[15:0];
            end
            default:   w_merged = r_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_merge  <= 32'd0;
            r_rdata  <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_rdata  <= 32'd0;
                        if (w_bad)                      r_state <= c_ERR;
                        else if (!req_write)            r_state <= c_LD;
                        else if (req_size == c_SZ_WORD) r_state <= c_WR;
                        else                            r_state <= c_RMW_RD;
                    end
                end
                c_LD: begin
                    r_rdata <= w_ld_data;
                    r_state <= c_RESP;
                end
                c_RMW_RD: begin
                    r_merge <= mem_rdata;
                    r_state <= c_RMW_WR;
                end
                c_RMW_WR, c_WR: r_state <= c_RESP;
                default:        r_state <= c_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == c_IDLE);
    // Gating with rst keeps an in-flight write from committing during reset.
    assign mem_read   = !rst && ((r_state == c_LD) || (r_state == c_RMW_RD));
    assign mem_write  = !rst && ((r_state == c_RMW_WR) || (r_state == c_WR));
    assign mem_adr    = {r_addr[31:2], 2'b00};
    assign mem_wdata  = (r_state == c_WR)     ? r_wdata  :
                        (r_state == c_RMW_WR) ? w_merged : 32'd0;
    assign resp_valid = (r_state == c_RESP) || (r_state == c_ERR);
    assign resp_err   = (r_state == c_ERR);
    assign resp_rdata = (r_state == c_RESP) ? r_rdata : 32'd0;

endmodule
`default_nettype wire
